// File: rtl/gate_bist_pkg.sv
// Shared constants and state encoding for the gate-bank self-test checker.
package gate_bist_pkg;
  localparam int Y_AND  = 0;
  localparam int Y_OR   = 1;
  localparam int Y_NAND = 2;
  localparam int Y_NOR  = 3;
  localparam int Y_XOR  = 4;
  localparam int Y_XNOR = 5;
  localparam int Y_NOT  = 6;
  localparam int Y_W    = 7;

  localparam int NUM_VECTORS = 4;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_e;
endpackage

// File: rtl/gate_bist_checker_if.sv
// Bundle between the checker and the gate bank / host: stimulus, samples, results.
interface gate_bist_checker_if
  import gate_bist_pkg::*;
#(
  parameter int ERR_W = 4
);
  logic             start;
  logic             a_o;
  logic             b_o;
  logic [Y_W-1:0]   y_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       first_fail_vec;
  logic [Y_W-1:0]   first_fail_mask;

  modport master (
    output start, y_in,
    input  a_o, b_o, busy, done, pass, err_count, first_fail_vec, first_fail_mask
  );

  modport slave (
    input  start, y_in,
    output a_o, b_o, busy, done, pass, err_count, first_fail_vec, first_fail_mask
  );
endinterface

// File: rtl/gate_golden.sv
// Golden truth table of the primitive gate bank for one {a,b} input pair.
module gate_golden
  import gate_bist_pkg::*;
(
  input  logic           a,
  input  logic           b,
  output logic [Y_W-1:0] expected
);
  always_comb begin
    expected         = '0;
    expected[Y_AND]  = a & b;
    expected[Y_OR]   = a | b;
    expected[Y_NAND] = ~(a & b);
    expected[Y_NOR]  = ~(a | b);
    expected[Y_XOR]  = a ^ b;
    expected[Y_XNOR] = a ~^ b;
    expected[Y_NOT]  = ~a;
  end
endmodule

// File: rtl/gate_bist_checker.sv
// Sweeps a/b through all vectors PASSES times, samples the gate bank after a
// settle delay and accumulates mismatch count plus the first failing vector.
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  gate_bist_checker_if.slave  bus
);
  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [PASS_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic             a_q, a_d, b_q, b_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [1:0]       ffv_q, ffv_d;
  logic [Y_W-1:0]   ffm_q, ffm_d;
  logic [Y_W-1:0]   exp_y, mism;

  // Expected value tracks the registered drive, so it lines up with y_in.
  gate_golden u_golden (.a(a_q), .b(b_q), .expected(exp_y));
  assign mism = bus.y_in ^ exp_y;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    pcnt_d  = pcnt_q;
    scnt_d  = scnt_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffm_d   = ffm_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = DRIVE;
          vec_d   = '0;
          pcnt_d  = '0;
          err_d   = '0;
          ffv_d   = '0;
          ffm_d   = '0;
        end
      end
      DRIVE: begin
        a_d     = vec_q[1];
        b_d     = vec_q[0];
        scnt_d  = '0;
        state_d = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        if (scnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = CHECK;
        else                                     scnt_d  = scnt_q + 1'b1;
      end
      CHECK: begin
        if (mism != '0) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          // err_q only reads zero until the run's first mismatch (it saturates)
          if (err_q == '0) begin
            ffv_d = {a_q, b_q};
            ffm_d = mism;
          end
        end
        if (vec_q != 2'(NUM_VECTORS - 1)) begin
          vec_d   = vec_q + 1'b1;
          state_d = DRIVE;
        end else if (pcnt_q != PASS_W'(PASSES - 1)) begin
          vec_d   = '0;
          pcnt_d  = pcnt_q + 1'b1;
          state_d = DRIVE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      pcnt_q  <= '0;
      scnt_q  <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffm_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      pcnt_q  <= pcnt_d;
      scnt_q  <= scnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffm_q   <= ffm_d;
    end
  end

  assign bus.a_o             = a_q;
  assign bus.b_o             = b_q;
  assign bus.busy            = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == CHECK);
  assign bus.done            = (state_q == DONE);
  assign bus.pass            = (state_q == DONE) && (err_q == '0);
  assign bus.err_count       = err_q;
  assign bus.first_fail_vec  = ffv_q;
  assign bus.first_fail_mask = ffm_q;
endmodule

// File: tb/tb_gate_bist_checker.sv
// Directed bench: golden table, fault-injected runs, reset abort, start corner cases.
module tb_gate_bist_checker;
  import gate_bist_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Fault controls for the two stand-in gate banks.
  logic           and0_0 = 1'b0;
  logic [Y_W-1:0] inv0 = '0;
  logic [Y_W-1:0] inv1 = '0;

  gate_bist_checker_if #(.ERR_W(4)) if0 ();
  gate_bist_checker_if #(.ERR_W(3)) if1 ();

  gate_bist_checker #(.SETTLE_CYCLES(2), .PASSES(1), .ERR_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  gate_bist_checker #(.SETTLE_CYCLES(2), .PASSES(2), .ERR_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  function automatic logic [Y_W-1:0] bank(input logic a, input logic b,
                                          input logic and0, input logic [Y_W-1:0] inv);
    logic [Y_W-1:0] y;
    y         = '0;
    y[Y_AND]  = and0 ? 1'b0 : (a & b);
    y[Y_OR]   = a | b;
    y[Y_NAND] = ~(a & b);
    y[Y_NOR]  = ~(a | b);
    y[Y_XOR]  = a ^ b;
    y[Y_XNOR] = ~(a ^ b);
    y[Y_NOT]  = ~a;
    return y ^ inv;
  endfunction

  assign if0.y_in = bank(if0.a_o, if0.b_o, and0_0, inv0);
  assign if1.y_in = bank(if1.a_o, if1.b_o, 1'b0, inv1);

  logic           gg_a, gg_b;
  logic [Y_W-1:0] gg_y;
  gate_golden u_gg (.a(gg_a), .b(gg_b), .expected(gg_y));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Start a run on dut0; optionally poke start at a given busy cycle or hold it high.
  task automatic run0(input int poke, input bit hold, output int ncyc);
    @(negedge clk) if0.start = 1'b1;
    @(negedge clk) if0.start = hold;
    ncyc = 0;
    while (if0.busy && ncyc < 1000) begin
      ncyc++;
      if (!hold) if0.start = (ncyc == poke);
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [1:0]     ab;
    logic [Y_W-1:0] exp;
  } gold_t;

  typedef struct {
    string          nm;
    logic           and0;
    logic [Y_W-1:0] inv;
    logic           pass;
    int             err;
    logic [1:0]     vec;
    logic [Y_W-1:0] mask;
  } run_t;

  gold_t gold[4];
  run_t  runs[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    if0.start = 1'b0;
    if1.start = 1'b0;

    gold[0] = '{2'b00, 7'h6C};
    gold[1] = '{2'b01, 7'h56};
    gold[2] = '{2'b10, 7'h16};
    gold[3] = '{2'b11, 7'h23};

    runs[0] = '{"clean",   1'b0, 7'h00, 1'b1, 0, 2'b00, 7'h00};
    runs[1] = '{"and0",    1'b1, 7'h00, 1'b0, 1, 2'b11, 7'h01};
    runs[2] = '{"xor_inv", 1'b0, 7'h10, 1'b0, 4, 2'b00, 7'h10};
    runs[3] = '{"not_inv", 1'b0, 7'h40, 1'b0, 4, 2'b00, 7'h40};

    for (int i = 0; i < 4; i++) begin
      {gg_a, gg_b} = gold[i].ab;
      #1;
      check($sformatf("golden[%0d]", i), 32'(gg_y), 32'(gold[i].exp));
    end

    repeat (3) @(negedge clk);
    check("rst a_o",  32'(if0.a_o), 0);
    check("rst b_o",  32'(if0.b_o), 0);
    check("rst busy", 32'(if0.busy), 0);
    check("rst done", 32'(if0.done), 0);
    check("rst pass", 32'(if0.pass), 0);
    check("rst err",  32'(if0.err_count), 0);
    check("rst ffv",  32'(if0.first_fail_vec), 0);
    check("rst ffm",  32'(if0.first_fail_mask), 0);
    check("rst busy1", 32'(if1.busy), 0);
    check("rst err1",  32'(if1.err_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      and0_0 = runs[i].and0;
      inv0   = runs[i].inv;
      run0(0, 1'b0, n);
      check({runs[i].nm, " cycles"}, 32'(n), 16);
      check({runs[i].nm, " done"},   32'(if0.done), 1);
      check({runs[i].nm, " pass"},   32'(if0.pass), 32'(runs[i].pass));
      check({runs[i].nm, " err"},    32'(if0.err_count), 32'(runs[i].err));
      check({runs[i].nm, " ffv"},    32'(if0.first_fail_vec), 32'(runs[i].vec));
      check({runs[i].nm, " ffm"},    32'(if0.first_fail_mask), 32'(runs[i].mask));
      check({runs[i].nm, " ab hold"}, 32'({if0.a_o, if0.b_o}), 3);
    end
    and0_0 = 1'b0;

    // Saturation: every bit wrong over two passes, 3-bit counter.
    inv1 = 7'h7F;
    @(negedge clk) if1.start = 1'b1;
    @(negedge clk) if1.start = 1'b0;
    n = 0;
    while (if1.busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("sat cycles", 32'(n), 32);
    check("sat done",   32'(if1.done), 1);
    check("sat pass",   32'(if1.pass), 0);
    check("sat err",    32'(if1.err_count), 7);
    check("sat ffv",    32'(if1.first_fail_vec), 0);
    check("sat ffm",    32'(if1.first_fail_mask), 32'h7F);

    // Abort in SETTLE of vector 2 (busy cycle 10).
    inv0 = 7'h10;
    @(negedge clk) if0.start = 1'b1;
    @(negedge clk) if0.start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort busy",  32'(if0.busy), 1);
    check("abort ab",    32'({if0.a_o, if0.b_o}), 2);
    check("abort err",   32'(if0.err_count), 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort2 busy", 32'(if0.busy), 0);
    check("abort2 done", 32'(if0.done), 0);
    check("abort2 pass", 32'(if0.pass), 0);
    check("abort2 ab",   32'({if0.a_o, if0.b_o}), 0);
    check("abort2 err",  32'(if0.err_count), 0);
    check("abort2 ffv",  32'(if0.first_fail_vec), 0);
    check("abort2 ffm",  32'(if0.first_fail_mask), 0);
    inv0 = '0;
    run0(0, 1'b0, n);
    check("fresh cycles", 32'(n), 16);
    check("fresh pass",   32'(if0.pass), 1);

    // start during busy is ignored.
    run0(5, 1'b0, n);
    check("poke cycles", 32'(n), 16);
    check("poke done",   32'(if0.done), 1);
    @(negedge clk);
    check("poke idle",   32'(if0.busy), 0);

    // start held through DONE retriggers back to back.
    run0(0, 1'b1, n);
    check("hold cycles", 32'(n), 16);
    check("hold done",   32'(if0.done), 1);
    @(negedge clk);
    if0.start = 1'b0;
    check("retrig done", 32'(if0.done), 0);
    check("retrig pass", 32'(if0.pass), 0);
    check("retrig busy", 32'(if0.busy), 1);
    n = 1;
    while (if0.busy && n < 1000) begin
      @(negedge clk);
      if (if0.busy) n++;
    end
    check("retrig cycles", 32'(n), 16);
    check("retrig pass2",  32'(if0.pass), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gate_bist_checker.md
Name: gate_bist_checker

Overview:
- Hardware self-test controller for the team's primitive gate bank: and_gate, or_gate, not_gate, nand_gate, nor_gate, xor_gate and xnor_gate.
- Drives the shared a/b inputs through all four combinations and samples the seven gate outputs after a settle delay.
- Compares the samples against a golden truth table and reports pass/fail, a mismatch count and the first failing vector.
- Sits beside the gate bank in a synthesizable wrapper, so the gates are checked on silicon/FPGA without a simulator.

Parameters:
- SETTLE_CYCLES, 2, idle cycles between driving a vector and sampling y_in; 0 is legal.
- PASSES, 1, number of full 4-vector sweeps per run; must be >= 1.
- ERR_W, 4, width of the saturating mismatch counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request a run; sampled only in IDLE or DONE.
- a_o  out  1  gate input A to the bank.
- b_o  out  1  gate input B to the bank.
- y_in  in  7  gate outputs. Bit 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT(A).
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next accepted start or reset.
- pass  out  1  valid while done=1; 1 iff err_count==0.
- err_count  out  ERR_W  number of vectors with at least one mismatching bit; saturates at all-ones.
- first_fail_vec  out  2  {a,b} of the first mismatching vector; 0 if none.
- first_fail_mask  out  7  y_in XOR expected at the first mismatch; 0 if none.

Behaviour:
- Reset: rst_n=0 at a clock edge forces state=IDLE and clears the vector index and pass counter. All outputs go to 0: a_o, b_o, busy, done, pass, err_count, first_fail_vec, first_fail_mask.
- Reset mid-run aborts the run with no partial results retained.
- States:
  - IDLE: waits for start.
  - DRIVE: registers a_o/b_o from the vector index; MSB is a, LSB is b.
  - SETTLE: counts SETTLE_CYCLES cycles; skipped when SETTLE_CYCLES=0.
  - CHECK: compares y_in against expected.
  - DONE: results held.
- Transitions:
  - IDLE/DONE with start=1 -> DRIVE. Vector=0, pass counter=0, err_count, first_fail_* and done cleared. busy=1 from the next cycle.
  - DRIVE -> SETTLE, or DRIVE -> CHECK when SETTLE_CYCLES=0.
  - SETTLE -> CHECK after SETTLE_CYCLES cycles.
  - CHECK:
    - If vector<3: vector+1, then -> DRIVE.
    - Else if pass counter<PASSES-1: vector=0, pass+1, then -> DRIVE.
    - Else -> DONE.
- Expected vector, a function of {a,b}: {~a, a~^b, a^b, ~(a|b), ~(a&b), a|b, a&b}, packed bit 6 down to bit 0.
- CHECK compare: mismatch = y_in XOR expected. If mismatch is nonzero:
  - err_count increments unless it is all-ones.
  - If this is the first mismatch of the run, first_fail_vec and first_fail_mask are captured.
- Latency: busy is high for exactly PASSES*4*(SETTLE_CYCLES+2) cycles. done and pass rise in the cycle busy falls.
- a_o/b_o hold the last vector (1,1) in DONE and return to 0 only on reset.
- start while busy is ignored: no restart, no queuing.
- start held high in DONE retriggers immediately; this back-to-back operation is legal.
- pass=0 whenever done=0.

Decomposition:
- Package gate_bist_pkg holds:
  - the y_in bit-index constants (Y_AND=0 … Y_NOT=6);
  - the state encoding (IDLE, DRIVE, SETTLE, CHECK, DONE);
  - the NUM_VECTORS=4 constant.
- One combinational sub-module, gate_golden: input a, b; output expected[6:0]. Reused by the bench scoreboard.

Test Plan:
- Real gate bank, defaults, start pulse at edge k -> busy high 16 cycles. At edge k+17: done=1, pass=1, err_count=0, first_fail_vec=0, first_fail_mask=0.
- AND output forced 0 -> err_count=1, first_fail_vec=2'b11, first_fail_mask=7'b0000001, pass=0.
- XOR output inverted -> err_count=4, first_fail_vec=2'b00, first_fail_mask=7'b0010000.
- All outputs inverted, PASSES=2, ERR_W=3 -> 8 mismatches saturate err_count at 7; first_fail_mask=7'h7F.
- rst_n=0 during SETTLE of vector 2 -> next cycle every output is 0 and state=IDLE. A fresh start then completes with pass=1.
- start pulsed again at busy cycle 5 -> ignored, run length unchanged (16 cycles). start held high through DONE -> new run begins the cycle after done rises, and done drops.
